// File: rtl/osd_event_packetizer_pkg.sv
// dii_package: constants and helpers shared by the DII event path.
//   TYPE_EVENT      - 2-bit packet class placed in the top of the TYPE word
//   WORD_DEST/SRC/TYPE - positions of the header words within a packet
//   HDR_WORDS       - number of header words
//   payload_words() - 16-bit words needed to carry a payload of a given width
package dii_package;

    localparam logic [1:0] TYPE_EVENT = 2'b10;

    localparam int WORD_DEST = 0;
    localparam int WORD_SRC  = 1;
    localparam int WORD_TYPE = 2;
    localparam int HDR_WORDS = 3;

    function automatic int payload_words(input int width);
        return (width + 15) / 16;
    endfunction

endpackage

// File: rtl/osd_event_packetizer_if.sv
// dii_channel: 16-bit DII word stream with packet framing.
//   data[15:0] - packet word
//   first      - first word of a packet
//   last       - last word of a packet
//   valid      - word present (master -> slave)
//   ready      - word taken on valid & ready (slave -> master)
interface dii_channel;
    logic [15:0] data;
    logic        first;
    logic        last;
    logic        valid;
    logic        ready;

    modport master (output data, output first, output last, output valid, input ready);
    modport slave  (input data, input first, input last, input valid, output ready);
endinterface

// File: rtl/osd_event_packetizer_timestamp.sv
// osd_timestamp: 32-bit free-running cycle counter with a capture register.
// Only built when OSD_PACKETIZER_TIMESTAMP_EN is defined.
//   clk, rst - clock, synchronous active-high reset
//   capture  - load the current counter value into ts
//   ts       - counter value seen in the most recent capture cycle
module osd_timestamp (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    output logic [31:0] ts
);

    logic [31:0] count;

    // count wraps naturally from 32'hFFFF_FFFF to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ts    <= '0;
        end else begin
            count <= count + 32'd1;
            if (capture) ts <= count;
        end
    end

endmodule

// File: rtl/osd_event_packetizer.sv
// osd_event_packetizer: turns one wide event into one DII packet:
//   DEST(first), SRC, TYPE, [TS_LO, TS_HI], payload words LSW first (last).
// Packet length is 3 + ceil(DATA_WIDTH/16), plus 2 with timestamps.
// Optional feature macro: OSD_PACKETIZER_TIMESTAMP_EN adds a captured
// 32-bit cycle count between TYPE and the payload.
//   clk, rst    - clock, synchronous active-high reset
//   id          - own address, sent as the SRC word
//   dest        - destination address, sent as the DEST word
//   event_data  - event payload (DATA_WIDTH bits)
//   event_valid - event present
//   event_ready - high only in IDLE; event taken on valid & ready
//   out         - DII master channel
module osd_event_packetizer
    import dii_package::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter logic [3:0] TYPE_SUB   = 4'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           id,
    input  logic [15:0]           dest,
    input  logic [DATA_WIDTH-1:0] event_data,
    input  logic                  event_valid,
    output logic                  event_ready,
    dii_channel.master            out
);

    localparam int PAYLOAD_WORDS = payload_words(DATA_WIDTH);
    localparam int PAD_W         = PAYLOAD_WORDS * 16;
    localparam int CNT_W         = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DEST,
        SRC,
        TYPE,
`ifdef OSD_PACKETIZER_TIMESTAMP_EN
        TS_LO,
        TS_HI,
`endif
        PAYLOAD
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]                   cnt;
    logic [PAYLOAD_WORDS-1:0][15:0]     data_q;
    logic [15:0]                        dest_q;
    logic [15:0]                        id_q;
    logic                               accept;
    logic                               xfer;
    logic                               last_word;

    assign accept    = (state == IDLE) && event_valid;
    assign xfer      = out.valid && out.ready;
    assign last_word = (cnt == CNT_W'(PAYLOAD_WORDS - 1));

`ifdef OSD_PACKETIZER_TIMESTAMP_EN
    logic [31:0] ts;

    osd_timestamp u_ts (
        .clk     (clk),
        .rst     (rst),
        .capture (accept),
        .ts      (ts)
    );
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // event capture and payload word counter; the zero-extension to PAD_W
    // provides the padding of the final payload word
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            data_q <= PAD_W'(event_data);
            dest_q <= dest;
            id_q   <= id;
            cnt    <= '0;
        end else if (state == PAYLOAD && xfer) begin
            cnt <= last_word ? '0 : cnt + 1'b1;
        end
    end

    // next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (event_valid)      state_next = DEST;
            DEST:    if (xfer)             state_next = SRC;
            SRC:     if (xfer)             state_next = TYPE;
`ifdef OSD_PACKETIZER_TIMESTAMP_EN
            TYPE:    if (xfer)             state_next = TS_LO;
            TS_LO:   if (xfer)             state_next = TS_HI;
            TS_HI:   if (xfer)             state_next = PAYLOAD;
`else
            TYPE:    if (xfer)             state_next = PAYLOAD;
`endif
            PAYLOAD: if (xfer && last_word) state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // outputs depend only on registered state, so they hold under backpressure
    always_comb begin
        event_ready = (state == IDLE);
        out.valid   = 1'b0;
        out.data    = 16'h0000;
        out.first   = 1'b0;
        out.last    = 1'b0;
        case (state)
            DEST: begin
                out.valid = 1'b1;
                out.data  = dest_q;
                out.first = 1'b1;
            end
            SRC: begin
                out.valid = 1'b1;
                out.data  = id_q;
            end
            TYPE: begin
                out.valid = 1'b1;
                out.data  = {TYPE_EVENT, TYPE_SUB, 10'h000};
            end
`ifdef OSD_PACKETIZER_TIMESTAMP_EN
            TS_LO: begin
                out.valid = 1'b1;
                out.data  = ts[15:0];
            end
            TS_HI: begin
                out.valid = 1'b1;
                out.data  = ts[31:16];
            end
`endif
            PAYLOAD: begin
                out.valid = 1'b1;
                out.data  = data_q[cnt];
                out.last  = last_word;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_osd_event_packetizer.sv
// Bench for osd_event_packetizer: a 40-bit instance carries the main tests,
// 16-bit and 20-bit instances cover the padding cases. Expected words are
// queued as {data, first, last} when an event is accepted and popped by
// per-instance monitors on each handshake.
module tb_osd_event_packetizer;

    typedef logic [17:0] word_t;

`ifdef OSD_PACKETIZER_TIMESTAMP_EN
    localparam int PKT40 = 8;
`else
    localparam int PKT40 = 6;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] id, dest;
    logic [39:0] ev_data;
    logic        ev_valid, ev_ready;
    logic [15:0] d16;
    logic        v16, r16;
    logic [19:0] d20;
    logic        v20, r20;
    logic [31:0] cyc;
    logic        bp;
    logic [3:0]  pat = 4'b1001;
    int          ph;

    int nvec = 0;
    int nerr = 0;

    word_t q40[$], q16[$], q20[$];

    always #5 clk = ~clk;

    dii_channel ch();
    dii_channel ch16();
    dii_channel ch20();

    osd_event_packetizer #(.DATA_WIDTH(40), .TYPE_SUB(4'h0)) dut (
        .clk(clk), .rst(rst), .id(id), .dest(dest), .event_data(ev_data),
        .event_valid(ev_valid), .event_ready(ev_ready), .out(ch)
    );

    osd_event_packetizer #(.DATA_WIDTH(16), .TYPE_SUB(4'h0)) dut16 (
        .clk(clk), .rst(rst), .id(id), .dest(dest), .event_data(d16),
        .event_valid(v16), .event_ready(r16), .out(ch16)
    );

    osd_event_packetizer #(.DATA_WIDTH(20), .TYPE_SUB(4'h3)) dut20 (
        .clk(clk), .rst(rst), .id(id), .dest(dest), .event_data(d20),
        .event_valid(v20), .event_ready(r20), .out(ch20)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // cycle model matching the timestamp counter: 0 after reset, +1 per cycle
    always @(posedge clk) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 32'd1;
    end

    // ready pattern 1,0,0,1 under backpressure, else always ready
    initial begin
        ch16.ready = 1'b1;
        ch20.ready = 1'b1;
        ch.ready   = 1'b1;
        ph         = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp) begin
                ch.ready = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                ch.ready = 1'b1;
            end
        end
    end

    // main monitor
    word_t hold_w;
    logic  hold = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            hold <= 1'b0;
        end else begin
            if (hold && ch.valid) check("hold40", {ch.data, ch.first, ch.last}, hold_w);
            if (ch.valid) check("busy_ready", ev_ready, 1'b0);
            hold   <= ch.valid && !ch.ready;
            hold_w <= {ch.data, ch.first, ch.last};
            if (ch.valid && ch.ready) begin
                check("q40_occ", q40.size() != 0, 1'b1);
                if (q40.size() != 0) check("word40", {ch.data, ch.first, ch.last}, q40.pop_front());
            end
        end
    end

    // padding-instance monitors
    always @(negedge clk) begin
        if (!rst && ch16.valid && ch16.ready) begin
            check("q16_occ", q16.size() != 0, 1'b1);
            if (q16.size() != 0) check("word16", {ch16.data, ch16.first, ch16.last}, q16.pop_front());
        end
        if (!rst && ch20.valid && ch20.ready) begin
            check("q20_occ", q20.size() != 0, 1'b1);
            if (q20.size() != 0) check("word20", {ch20.data, ch20.first, ch20.last}, q20.pop_front());
        end
    end

    task automatic push40(input logic [15:0] d, input logic [15:0] i, input logic [39:0] x,
                          input logic [31:0] ts);
        logic [47:0] p;
        p = {8'h00, x};
        q40.push_back({d, 2'b10});
        q40.push_back({i, 2'b00});
        q40.push_back({16'h8000, 2'b00});
`ifdef OSD_PACKETIZER_TIMESTAMP_EN
        q40.push_back({ts[15:0], 2'b00});
        q40.push_back({ts[31:16], 2'b00});
`else
        if (ts[0] === 1'bx) $display("note: unexpected x in cycle model");
`endif
        for (int k = 0; k < 3; k++) q40.push_back({p[16*k +: 16], 1'b0, k == 2});
    endtask

    // present an event; returns the model cycle at acceptance
    task automatic send40(input logic [15:0] d, input logic [15:0] i, input logic [39:0] x,
                          input bit keep_valid, output logic [31:0] acc);
        dest = d; id = i; ev_data = x; ev_valid = 1'b1;
        acc = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ev_ready) break;
        end
        check("accept40", ev_ready, 1'b1);
        acc = cyc;
        push40(d, i, x, cyc);
        @(posedge clk);
        #1;
        if (!keep_valid) ev_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && (q40.size() + q16.size() + q20.size()) != 0; n++) @(negedge clk);
        check("drain", q40.size() + q16.size() + q20.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] a1, a2;
    int          busy;

    initial begin
        bp = 1'b0; ev_valid = 1'b0; v16 = 1'b0; v20 = 1'b0;
        id = '0; dest = '0; ev_data = '0; d16 = '0; d20 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_valid", ch.valid, 1'b0);
        check("rst_first", ch.first, 1'b0);
        check("rst_last", ch.last, 1'b0);
        check("rst_data", ch.data, 16'h0000);
        check("rst_ready", ev_ready, 1'b1);

        // basic packet and busy window
        send40(16'h0001, 16'h0005, 40'h12_3456_789A, 1'b0, a1);
        busy = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ev_ready) break;
            busy++;
        end
        check("busy_cycles", busy, PKT40);
        drain();

        // backpressure: same packet, ready toggling
        bp = 1'b1;
        send40(16'h0001, 16'h0005, 40'h12_3456_789A, 1'b0, a1);
        drain();
        for (int r = 0; r < 3; r++) begin
            send40(16'($urandom), 16'($urandom), {8'($urandom), 32'($urandom)}, 1'b0, a1);
            drain();
        end
        bp = 1'b0;

        // input isolation and back-to-back acceptance spacing
        send40(16'h00A1, 16'h00B2, 40'hAA_BBCC_DDEE, 1'b1, a1);
        send40(16'h0C3D, 16'h0E4F, 40'h55_6677_8899, 1'b0, a2);
        check("b2b_gap", a2 - a1, PKT40 + 1);
        drain();

        // reset while the SRC word is on the bus
        send40(16'h0111, 16'h0222, 40'h01_0203_0405, 1'b0, a1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q40.delete();
        check("mid_rst_valid", ch.valid, 1'b0);
        check("mid_rst_ready", ev_ready, 1'b1);
        send40(16'h0333, 16'h0444, 40'h0F_1E2D_3C4B, 1'b0, a1);
        drain();

        // 16-bit payload: 4 words, payload word carries last
        dest = 16'h0007; id = 16'h0009; d16 = 16'hBEEF; v16 = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (r16) break;
        end
        check("accept16", r16, 1'b1);
        q16.push_back({16'h0007, 2'b10});
        q16.push_back({16'h0009, 2'b00});
        q16.push_back({16'h8000, 2'b00});
        q16.push_back({16'hBEEF, 2'b01});
        @(posedge clk);
        #1 v16 = 1'b0;
        drain();

        // 20-bit payload: top word zero-padded, subtype 3
        dest = 16'h0002; id = 16'h0004; d20 = 20'hF_ABCD; v20 = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (r20) break;
        end
        check("accept20", r20, 1'b1);
        q20.push_back({16'h0002, 2'b10});
        q20.push_back({16'h0004, 2'b00});
        q20.push_back({16'h8C00, 2'b00});
        q20.push_back({16'hABCD, 2'b00});
        q20.push_back({16'h000F, 2'b01});
        @(posedge clk);
        #1 v20 = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
